// File: rtl/host_input_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : host_input_dispatch
// Purpose  : Host-port input queue. Splits incoming descriptors into the
//            time-sensitive (TS) path, which writes a per-flow slot in the TS
//            descriptor RAM, and the non-TS path, which is an internal
//            first-word-fall-through FIFO drained with valid/ready. A TS packet
//            that finds its slot occupied (or targets a slot beyond
//            TS_FLOW_NUM) is redirected to the FIFO with an all-ones inport so
//            the output stage frees its buffer. Saturating statistics counters
//            are kept.
// Ports    : i_clk/i_rst_n            clock, async active-low reset
//            iv_bufid/iv_pkt_type/iv_pkt_inport/iv_ts_submit_addr/i_data_wr
//                                     incoming descriptor and strobe
//            iv_ts_type_mask          per-type TS classification mask
//            i_ts_release/iv_ts_release_addr  slot release from TIM
//            ov_ts_descriptor_*/o_ts_descriptor_wr  TS RAM write port
//            ov_ts_valid              slot occupancy map
//            ov_nts_descriptor_data/o_nts_descriptor_valid/
//            i_nts_descriptor_ready   FIFO head, valid/ready drain
//            ov_nts_fifo_cnt          FIFO occupancy
//            o_ts_overflow_error_pulse/o_host_inqueue_discard_pulse  events
//            i_cnt_clear, ov_*_cnt    statistics
// Revision : 1.0 - initial release
// ============================================================================
module host_input_dispatch #(
   parameter int BUFID_W     = 9,
   parameter int PORT_W      = 4,
   parameter int TS_FLOW_NUM = 32,
   parameter int TS_ADDR_W   = 5,
   parameter int FIFO_AW     = 4,
   parameter int CNT_W       = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [BUFID_W-1:0]          iv_bufid,
   input  logic [2:0]                  iv_pkt_type,
   input  logic [PORT_W-1:0]           iv_pkt_inport,
   input  logic [TS_ADDR_W-1:0]        iv_ts_submit_addr,
   input  logic                        i_data_wr,
   input  logic [7:0]                  iv_ts_type_mask,
   input  logic                        i_ts_release,
   input  logic [TS_ADDR_W-1:0]        iv_ts_release_addr,
   output logic [PORT_W+BUFID_W-1:0]   ov_ts_descriptor_wdata,
   output logic                        o_ts_descriptor_wr,
   output logic [TS_ADDR_W-1:0]        ov_ts_descriptor_waddr,
   output logic [TS_FLOW_NUM-1:0]      ov_ts_valid,
   output logic [PORT_W+BUFID_W-1:0]   ov_nts_descriptor_data,
   output logic                        o_nts_descriptor_valid,
   input  logic                        i_nts_descriptor_ready,
   output logic [FIFO_AW:0]            ov_nts_fifo_cnt,
   output logic                        o_ts_overflow_error_pulse,
   output logic                        o_host_inqueue_discard_pulse,
   input  logic                        i_cnt_clear,
   output logic [CNT_W-1:0]            ov_ts_cnt,
   output logic [CNT_W-1:0]            ov_total_cnt,
   output logic [CNT_W-1:0]            ov_ts_overflow_cnt,
   output logic [CNT_W-1:0]            ov_discard_cnt
);

   localparam int c_desc_w = PORT_W + BUFID_W;
   localparam int c_depth  = 1 << FIFO_AW;

   // ------------------------------------------------------------------------
   // Classification and slot arbitration
   // ------------------------------------------------------------------------
   logic [TS_FLOW_NUM-1:0] r_ts_valid;
   logic [TS_FLOW_NUM-1:0] w_addr_hit;
   logic [TS_FLOW_NUM-1:0] w_rel_hit;
   logic [TS_FLOW_NUM-1:0] w_ts_valid_nxt;
   logic                   w_is_ts;
   logic                   w_addr_ok;
   logic                   w_same_rel;
   logic                   w_slot_busy;
   logic                   w_ts_accept;
   logic                   w_ts_ovf;
   logic                   w_push;
   logic [c_desc_w-1:0]    w_push_data;

   // One-hot slot decodes. Addresses at or above TS_FLOW_NUM decode to no
   // slot at all, which is how out-of-range submissions become overflows.
   always_comb begin
      w_addr_hit = '0;
      w_rel_hit  = '0;
      for (int i = 0; i < TS_FLOW_NUM; i++) begin
         w_addr_hit[i] = (iv_ts_submit_addr == TS_ADDR_W'(i));
         w_rel_hit[i]  = i_ts_release && (iv_ts_release_addr == TS_ADDR_W'(i));
      end
   end

   assign w_is_ts     = i_data_wr & iv_ts_type_mask[iv_pkt_type];
   assign w_addr_ok   = |w_addr_hit;
   // A release of the very slot being submitted frees it in the same cycle.
   assign w_same_rel  = i_ts_release & (iv_ts_release_addr == iv_ts_submit_addr);
   assign w_slot_busy = |(r_ts_valid & w_addr_hit);
   assign w_ts_accept = w_is_ts & w_addr_ok & (~w_slot_busy | w_same_rel);
   assign w_ts_ovf    = w_is_ts & ~w_ts_accept;
   assign w_push      = i_data_wr & ~w_ts_accept;
   assign w_push_data = w_ts_ovf ? {{PORT_W{1'b1}}, iv_bufid}
                                 : {iv_pkt_inport, iv_bufid};

   // Set is applied after clear so a same-cycle write keeps the bit high.
   assign w_ts_valid_nxt = (r_ts_valid & ~w_rel_hit)
                         | (w_addr_hit & {TS_FLOW_NUM{w_ts_accept}});

   // ------------------------------------------------------------------------
   // NTS FIFO (first-word fall-through)
   // ------------------------------------------------------------------------
   logic [c_desc_w-1:0] r_mem [c_depth];
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [FIFO_AW:0]    r_cnt;
   logic [FIFO_AW:0]    w_cnt_nxt;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push_ok;
   logic                w_discard;

   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == (FIFO_AW+1)'(c_depth));
   assign w_pop     = ~w_empty & i_nts_descriptor_ready;
   // When full, a same-cycle pop frees the entry the push lands in.
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_discard = w_push & w_full & ~w_pop;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push_ok, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + (FIFO_AW+1)'(1);
         2'b01:   w_cnt_nxt = r_cnt - (FIFO_AW+1)'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Storage carries no reset; emptiness is tracked by the pointers/count.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   assign ov_nts_descriptor_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_nts_descriptor_valid = ~w_empty;
   assign ov_nts_fifo_cnt        = r_cnt;
   assign ov_ts_valid            = r_ts_valid;

   // ------------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------------
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic             inc);
      return (inc && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ts_valid                   <= '0;
         r_wr_ptr                     <= '0;
         r_rd_ptr                     <= '0;
         r_cnt                        <= '0;
         o_ts_descriptor_wr           <= 1'b0;
         ov_ts_descriptor_wdata       <= '0;
         ov_ts_descriptor_waddr       <= '0;
         o_ts_overflow_error_pulse    <= 1'b0;
         o_host_inqueue_discard_pulse <= 1'b0;
         ov_ts_cnt                    <= '0;
         ov_total_cnt                 <= '0;
         ov_ts_overflow_cnt           <= '0;
         ov_discard_cnt               <= '0;
      end else begin
         r_ts_valid <= w_ts_valid_nxt;
         r_cnt      <= w_cnt_nxt;
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end

         o_ts_descriptor_wr     <= w_ts_accept;
         ov_ts_descriptor_wdata <= w_ts_accept ? {iv_pkt_inport, iv_bufid} : '0;
         ov_ts_descriptor_waddr <= w_ts_accept ? iv_ts_submit_addr : '0;

         o_ts_overflow_error_pulse    <= w_ts_ovf;
         o_host_inqueue_discard_pulse <= w_discard;

         if (i_cnt_clear) begin
            ov_ts_cnt          <= '0;
            ov_total_cnt       <= '0;
            ov_ts_overflow_cnt <= '0;
            ov_discard_cnt     <= '0;
         end else begin
            ov_ts_cnt          <= f_sat_inc(ov_ts_cnt, w_is_ts);
            ov_total_cnt       <= f_sat_inc(ov_total_cnt, i_data_wr);
            ov_ts_overflow_cnt <= f_sat_inc(ov_ts_overflow_cnt, w_ts_ovf);
            ov_discard_cnt     <= f_sat_inc(ov_discard_cnt, w_discard);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_host_input_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_input_dispatch
// Purpose  : Directed self-checking bench for host_input_dispatch. A second
//            instance with 4-bit counters shares all inputs and is used for
//            the saturation check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_input_dispatch;

   logic        clk;
   logic        rst_n;
   logic [8:0]  bufid;
   logic [2:0]  pkt_type;
   logic [3:0]  inport;
   logic [4:0]  ts_addr;
   logic        data_wr;
   logic [7:0]  ts_mask;
   logic        ts_release;
   logic [4:0]  rel_addr;
   logic        nts_ready;
   logic        cnt_clear;

   logic [12:0] ts_wdata;
   logic        ts_wr;
   logic [4:0]  ts_waddr;
   logic [31:0] ts_valid;
   logic [12:0] nts_data;
   logic        nts_valid;
   logic [4:0]  fifo_cnt;
   logic        ovf_pulse;
   logic        disc_pulse;
   logic [15:0] ts_cnt, total_cnt, ovf_cnt, disc_cnt;

   logic [12:0] s_ts_wdata;
   logic        s_ts_wr;
   logic [4:0]  s_ts_waddr;
   logic [31:0] s_ts_valid;
   logic [12:0] s_nts_data;
   logic        s_nts_valid;
   logic [4:0]  s_fifo_cnt;
   logic        s_ovf_pulse;
   logic        s_disc_pulse;
   logic [3:0]  s_ts_cnt, s_total_cnt, s_ovf_cnt, s_disc_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   host_input_dispatch u_dut (
      .i_clk                        (clk),
      .i_rst_n                      (rst_n),
      .iv_bufid                     (bufid),
      .iv_pkt_type                  (pkt_type),
      .iv_pkt_inport                (inport),
      .iv_ts_submit_addr            (ts_addr),
      .i_data_wr                    (data_wr),
      .iv_ts_type_mask              (ts_mask),
      .i_ts_release                 (ts_release),
      .iv_ts_release_addr           (rel_addr),
      .ov_ts_descriptor_wdata       (ts_wdata),
      .o_ts_descriptor_wr           (ts_wr),
      .ov_ts_descriptor_waddr       (ts_waddr),
      .ov_ts_valid                  (ts_valid),
      .ov_nts_descriptor_data       (nts_data),
      .o_nts_descriptor_valid       (nts_valid),
      .i_nts_descriptor_ready       (nts_ready),
      .ov_nts_fifo_cnt              (fifo_cnt),
      .o_ts_overflow_error_pulse    (ovf_pulse),
      .o_host_inqueue_discard_pulse (disc_pulse),
      .i_cnt_clear                  (cnt_clear),
      .ov_ts_cnt                    (ts_cnt),
      .ov_total_cnt                 (total_cnt),
      .ov_ts_overflow_cnt           (ovf_cnt),
      .ov_discard_cnt               (disc_cnt)
   );

   host_input_dispatch #(.CNT_W(4)) u_dut_sat (
      .i_clk                        (clk),
      .i_rst_n                      (rst_n),
      .iv_bufid                     (bufid),
      .iv_pkt_type                  (pkt_type),
      .iv_pkt_inport                (inport),
      .iv_ts_submit_addr            (ts_addr),
      .i_data_wr                    (data_wr),
      .iv_ts_type_mask              (ts_mask),
      .i_ts_release                 (ts_release),
      .iv_ts_release_addr           (rel_addr),
      .ov_ts_descriptor_wdata       (s_ts_wdata),
      .o_ts_descriptor_wr           (s_ts_wr),
      .ov_ts_descriptor_waddr       (s_ts_waddr),
      .ov_ts_valid                  (s_ts_valid),
      .ov_nts_descriptor_data       (s_nts_data),
      .o_nts_descriptor_valid       (s_nts_valid),
      .i_nts_descriptor_ready       (nts_ready),
      .ov_nts_fifo_cnt              (s_fifo_cnt),
      .o_ts_overflow_error_pulse    (s_ovf_pulse),
      .o_host_inqueue_discard_pulse (s_disc_pulse),
      .i_cnt_clear                  (cnt_clear),
      .ov_ts_cnt                    (s_ts_cnt),
      .ov_total_cnt                 (s_total_cnt),
      .ov_ts_overflow_cnt           (s_ovf_cnt),
      .ov_discard_cnt               (s_disc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      data_wr    = 1'b0;
      ts_release = 1'b0;
      nts_ready  = 1'b0;
      cnt_clear  = 1'b0;
   endtask

   task automatic pkt(input logic [2:0] t, input logic [3:0] p,
                      input logic [8:0] b, input logic [4:0] a);
      data_wr  = 1'b1;
      pkt_type = t;
      inport   = p;
      bufid    = b;
      ts_addr  = a;
   endtask

   logic [12:0] exp_head [16];

   initial begin
      rst_n    = 1'b0;
      bufid    = '0;
      pkt_type = '0;
      inport   = '0;
      ts_addr  = '0;
      rel_addr = '0;
      ts_mask  = 8'h07;
      idle();
      repeat (2) tick();

      // Reset state
      check_eq("rst_ts_wr",     ts_wr,     0);
      check_eq("rst_nts_valid", nts_valid, 0);
      check_eq("rst_fifo_cnt",  fifo_cnt,  0);
      check_eq("rst_ts_valid",  ts_valid,  0);
      check_eq("rst_total_cnt", total_cnt, 0);
      rst_n = 1'b1;
      tick();

      // TS write to free slot 5
      pkt(3'd0, 4'd3, 9'h01A, 5'd5);
      tick();
      check_eq("ts_wr",       ts_wr,    1);
      check_eq("ts_waddr",    ts_waddr, 5);
      check_eq("ts_wdata",    ts_wdata, 13'h061A);
      check_eq("ts_valid5",   ts_valid, 32'h0000_0020);
      check_eq("ts_cnt1",     ts_cnt,   1);

      // Second TS packet to occupied slot 5 -> overflow into FIFO
      pkt(3'd1, 4'd2, 9'h022, 5'd5);
      tick();
      check_eq("ovf_no_ts_wr",   ts_wr,     0);
      check_eq("ovf_waddr_zero", ts_waddr,  0);
      check_eq("ovf_pulse",      ovf_pulse, 1);
      check_eq("ovf_head",       nts_data,  13'h1E22);
      check_eq("ovf_valid",      nts_valid, 1);
      check_eq("ovf_cnt1",       ovf_cnt,   1);
      check_eq("total_cnt2",     total_cnt, 2);

      // Release and write of slot 5 in the same cycle
      pkt(3'd2, 4'd1, 9'h033, 5'd5);
      ts_release = 1'b1;
      rel_addr   = 5'd5;
      tick();
      check_eq("coll_ts_wr",    ts_wr,     1);
      check_eq("coll_wdata",    ts_wdata,  13'h0233);
      check_eq("coll_valid5",   ts_valid,  32'h0000_0020);
      check_eq("coll_no_ovf",   ovf_pulse, 0);
      check_eq("coll_ovf_cnt",  ovf_cnt,   1);
      check_eq("ts_cnt3",       ts_cnt,    3);

      // Plain release, then release of an already-clear slot
      idle();
      ts_release = 1'b1;
      rel_addr   = 5'd5;
      tick();
      check_eq("rel_clear5", ts_valid, 0);
      rel_addr = 5'd7;
      tick();
      check_eq("rel_noop7",  ts_valid, 0);

      // Pop the overflowed descriptor
      idle();
      nts_ready = 1'b1;
      tick();
      check_eq("pop_cnt0",   fifo_cnt,  0);
      check_eq("pop_valid0", nts_valid, 0);
      check_eq("pop_data0",  nts_data,  0);

      // Fill the FIFO with 16 NTS descriptors, ready low
      idle();
      for (int i = 0; i < 16; i++) begin
         pkt(3'd4, 4'd5, 9'(9'h040 + i), 5'd0);
         tick();
      end
      check_eq("full_cnt16",    fifo_cnt,   16);
      check_eq("full_no_disc",  disc_pulse, 0);
      check_eq("full_head",     nts_data,   13'h0A40);

      // 17th push with no pop -> dropped
      pkt(3'd4, 4'd5, 9'h050, 5'd0);
      tick();
      check_eq("drop_pulse",    disc_pulse, 1);
      check_eq("drop_cnt16",    fifo_cnt,   16);
      check_eq("drop_disc_cnt", disc_cnt,   1);
      check_eq("drop_head",     nts_data,   13'h0A40);

      // Push while full but with a pop -> accepted
      pkt(3'd4, 4'd5, 9'h060, 5'd0);
      nts_ready = 1'b1;
      tick();
      check_eq("pp_cnt16",    fifo_cnt,   16);
      check_eq("pp_no_disc",  disc_pulse, 0);
      check_eq("pp_disc_cnt", disc_cnt,   1);
      check_eq("pp_head",     nts_data,   13'h0A41);

      // Drain and check order: 0x41..0x4F, then 0x60
      for (int j = 0; j < 15; j++) exp_head[j] = {4'h5, 9'(9'h041 + j)};
      exp_head[15] = {4'h5, 9'h060};
      idle();
      nts_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         check_eq($sformatf("drain_head%0d", j), nts_data, exp_head[j]);
         tick();
      end
      check_eq("drain_cnt0",   fifo_cnt,  0);
      check_eq("drain_valid0", nts_valid, 0);
      check_eq("total_cnt21",  total_cnt, 21);

      // Type mask 8'h08: type 3 is TS, type 0 is NTS
      idle();
      ts_mask = 8'h08;
      pkt(3'd3, 4'd2, 9'h010, 5'd9);
      tick();
      check_eq("mask_ts_wr",    ts_wr,    1);
      check_eq("mask_ts_waddr", ts_waddr, 9);
      check_eq("mask_ts_wdata", ts_wdata, 13'h0410);
      check_eq("mask_ts_valid", ts_valid, 32'h0000_0200);
      pkt(3'd0, 4'd6, 9'h055, 5'd9);
      tick();
      check_eq("mask_nts_no_wr", ts_wr,     0);
      check_eq("mask_nts_head",  nts_data,  13'h0C55);
      check_eq("mask_nts_valid", nts_valid, 1);
      check_eq("mask_no_ovf",    ovf_pulse, 0);

      // Asynchronous reset mid-operation
      idle();
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_cnt",   fifo_cnt,  0);
      check_eq("mid_rst_valid", nts_valid, 0);
      check_eq("mid_rst_ts",    ts_valid,  0);
      check_eq("mid_rst_total", total_cnt, 0);
      #2;
      rst_n = 1'b1;
      tick();

      // Saturation: 20 packets into a 4-bit counter
      ts_mask   = 8'h07;
      nts_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pkt(3'd5, 4'd1, 9'(i), 5'd0);
         tick();
      end
      check_eq("sat_total15", s_total_cnt, 15);
      check_eq("sat_total20", total_cnt,   20);
      check_eq("sat_ts_cnt0", s_ts_cnt,    0);

      // Clear wins over a coincident increment
      pkt(3'd5, 4'd1, 9'h001, 5'd0);
      cnt_clear = 1'b1;
      tick();
      check_eq("clr_sat_total", s_total_cnt, 0);
      check_eq("clr_total",     total_cnt,   0);
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
